mem_port_arbiter: RTL and testbench

Shares the single memory port between the fetch stage (instruction reads) and the memory stage (loads and stores). It grants one access at a time and times the fixed memory latency with a down-counter. It returns a one-cycle acknowledge with read data to the owner, and drives the `stall_if` / `stall_mem` requests consumed by pipeline control alongside the load-use hazard stalls.

---
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between instruction fetch and the data (load/store)
//   stage. One access is in flight at a time. The memory latency is timed with
//   a down-counter. The owner receives a one-cycle ack together with the read
//   data. Stall requests for pipeline control are derived from request/ack.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   if_req/if_addr             fetch request (level, held until if_ack)
//   if_ack/if_rdata            fetch completion pulse and data (0 unless ack)
//   d_req/d_we/d_addr/
//   d_wdata/d_be               data request (level, held until d_ack)
//   d_ack/d_rdata              data completion pulse and load data (0 unless ack)
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_be           memory issue strobe and access fields
//   mem_rdata                  read data, valid MEM_LAT cycles after mem_en
//   stall_if/stall_mem         request pending and not yet acknowledged
module mem_port_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MEM_LAT = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_ack,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic                d_ack,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                stall_if,
   output logic                stall_mem
);

   localparam logic [2:0] CntInit = 3'(MEM_LAT - 1);

   typedef enum logic {StIdle, StBusy} state_e;
   typedef enum logic {OwnFetch, OwnData} owner_e;

   state_e     state_q, state_d;
   owner_e     owner_q, owner_d;
   owner_e     last_q, last_d;
   logic [2:0] cnt_q, cnt_d;
   logic       we_q, we_d;   // in-flight access is a store: no read data returned

   logic grant_data;

   // Data wins when alone, or on a tie when fetch was granted last.
   assign grant_data = d_req & (~if_req | (last_q == OwnFetch));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         owner_q <= OwnFetch;
         last_q  <= OwnFetch;
         cnt_q   <= 3'd0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = '0;
      if_ack    = 1'b0;
      if_rdata  = '0;
      d_ack     = 1'b0;
      d_rdata   = '0;

      // Outputs held at 0 during reset; state is cleared by the register.
      if (!rst) begin
         unique case (state_q)
            StIdle: begin
               if (if_req || d_req) begin
                  mem_en = 1'b1;
                  if (grant_data) begin
                     mem_we    = d_we;
                     mem_addr  = d_addr;
                     mem_wdata = d_we ? d_wdata : '0;
                     mem_be    = d_we ? d_be : '1;
                     owner_d   = OwnData;
                     last_d    = OwnData;
                     we_d      = d_we;
                  end else begin
                     mem_addr = if_addr;
                     mem_be   = '1;
                     owner_d  = OwnFetch;
                     last_d   = OwnFetch;
                     we_d     = 1'b0;
                  end
                  cnt_d   = CntInit;
                  state_d = StBusy;
               end
            end
            StBusy: begin
               if (cnt_q != 3'd0) begin
                  cnt_d = cnt_q - 3'd1;
               end else begin
                  if (owner_q == OwnData) begin
                     d_ack   = 1'b1;
                     d_rdata = we_q ? '0 : mem_rdata;
                  end else begin
                     if_ack   = 1'b1;
                     if_rdata = mem_rdata;
                  end
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign stall_if  = ~rst & if_req & ~if_ack;
   assign stall_mem = ~rst & d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_be;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata;
   logic        stall_if;
   logic        stall_mem;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter #(
      .ADDR_W (32),
      .DATA_W (32),
      .MEM_LAT(2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_ack   (if_ack),
      .if_rdata (if_rdata),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_be     (d_be),
      .d_ack    (d_ack),
      .d_rdata  (d_rdata),
      .mem_en   (mem_en),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_be   (mem_be),
      .mem_rdata(mem_rdata),
      .stall_if (stall_if),
      .stall_mem(stall_mem)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Close the current cycle; inputs for the next cycle are applied 1 after the edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle before checking.
   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      if_req = 1'b0;
      d_req  = 1'b0;
      d_we   = 1'b0;
      next_cycle();
      next_cycle();
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      if_req    = 1'b0;
      if_addr   = 32'h100;
      d_req     = 1'b0;
      d_we      = 1'b0;
      d_addr    = 32'h300;
      d_wdata   = 32'h0;
      d_be      = 4'h0;
      mem_rdata = 32'hBAD0BAD0;
      #1;

      // 1. Reset held 3 cycles with both requests high
      if_req = 1'b1;
      d_req  = 1'b1;
      for (int c = 0; c < 3; c++) begin
         settle();
         chk("rst_mem_en", mem_en, 0);
         chk("rst_mem_addr", mem_addr, 0);
         chk("rst_mem_be", mem_be, 0);
         chk("rst_acks", {if_ack, d_ack}, 0);
         chk("rst_stalls", {stall_if, stall_mem}, 0);
         next_cycle();
      end
      rst = 1'b0;
      settle();
      chk("rel_mem_en", mem_en, 1);
      chk("rel_mem_addr", mem_addr, 32'h300);
      chk("rel_stalls", {stall_if, stall_mem}, 2'b11);
      next_cycle();
      settle();
      chk("rel_busy_en", mem_en, 0);
      next_cycle();
      mem_rdata = 32'hA5A5A5A5;
      settle();
      chk("rel_d_ack", d_ack, 1);
      chk("rel_d_rdata", d_rdata, 32'hA5A5A5A5);
      chk("rel_if_ack", if_ack, 0);
      next_cycle();
      mem_rdata = 32'hBAD0BAD0;
      do_reset();

      // 2. Lone fetch
      if_req  = 1'b1;
      if_addr = 32'h100;
      settle();
      chk("lf_en", mem_en, 1);
      chk("lf_addr", mem_addr, 32'h100);
      chk("lf_we", mem_we, 0);
      chk("lf_be", mem_be, 4'hF);
      chk("lf_stall0", stall_if, 1);
      next_cycle();
      settle();
      chk("lf_en1", mem_en, 0);
      chk("lf_stall1", stall_if, 1);
      chk("lf_ack1", if_ack, 0);
      chk("lf_rdata1", if_rdata, 0);
      next_cycle();
      mem_rdata = 32'hDEADBEEF;
      settle();
      chk("lf_ack2", if_ack, 1);
      chk("lf_rdata2", if_rdata, 32'hDEADBEEF);
      chk("lf_stall2", stall_if, 0);
      chk("lf_dack2", d_ack, 0);
      next_cycle();
      if_req    = 1'b0;
      mem_rdata = 32'hBAD0BAD0;
      settle();
      chk("lf_idle_en", mem_en, 0);
      chk("lf_idle_ack", if_ack, 0);
      do_reset();

      // 3. Tie after reset: data first, then fetch
      if_req = 1'b1;
      d_req  = 1'b1;
      settle();
      chk("tie_en0", mem_en, 1);
      chk("tie_addr0", mem_addr, 32'h300);
      chk("tie_stall0", {stall_if, stall_mem}, 2'b11);
      next_cycle();
      settle();
      chk("tie_en1", mem_en, 0);
      chk("tie_stall1", stall_if, 1);
      next_cycle();
      mem_rdata = 32'h11112222;
      settle();
      chk("tie_dack2", d_ack, 1);
      chk("tie_drdata2", d_rdata, 32'h11112222);
      chk("tie_ifack2", if_ack, 0);
      chk("tie_stall2", {stall_if, stall_mem}, 2'b10);
      next_cycle();
      d_req     = 1'b0;
      mem_rdata = 32'hBAD0BAD0;
      settle();
      chk("tie_en3", mem_en, 1);
      chk("tie_addr3", mem_addr, 32'h100);
      chk("tie_stall3", stall_if, 1);
      next_cycle();
      settle();
      chk("tie_stall4", stall_if, 1);
      next_cycle();
      mem_rdata = 32'h33334444;
      settle();
      chk("tie_ifack5", if_ack, 1);
      chk("tie_ifrdata5", if_rdata, 32'h33334444);
      chk("tie_stall5", stall_if, 0);
      next_cycle();
      if_req    = 1'b0;
      mem_rdata = 32'hBAD0BAD0;
      do_reset();

      // 4. Continuous contention: D, F, D, F at cycles 0, 3, 6, 9
      if_req = 1'b1;
      d_req  = 1'b1;
      for (int c = 0; c < 12; c++) begin
         settle();
         chk("cont_en", mem_en, (c % 3 == 0) ? 1 : 0);
         if (c % 3 == 0)
            chk("cont_addr", mem_addr, ((c / 3) % 2 == 0) ? 32'h300 : 32'h100);
         chk("cont_dack", d_ack, (c % 3 == 2 && (c / 3) % 2 == 0) ? 1 : 0);
         chk("cont_ifack", if_ack, (c % 3 == 2 && (c / 3) % 2 == 1) ? 1 : 0);
         next_cycle();
      end
      do_reset();

      // 5. Store
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h200;
      d_wdata = 32'h1234;
      d_be    = 4'h3;
      settle();
      chk("st_en", mem_en, 1);
      chk("st_we", mem_we, 1);
      chk("st_addr", mem_addr, 32'h200);
      chk("st_be", mem_be, 4'h3);
      chk("st_wdata", mem_wdata, 32'h1234);
      next_cycle();
      next_cycle();
      mem_rdata = 32'hCAFEF00D;
      settle();
      chk("st_ack", d_ack, 1);
      chk("st_rdata", d_rdata, 0);
      next_cycle();
      d_req     = 1'b0;
      d_we      = 1'b0;
      mem_rdata = 32'hBAD0BAD0;
      do_reset();

      // 6. Reset mid-access drops the fetch; re-issue after release
      if_req  = 1'b1;
      if_addr = 32'h100;
      settle();
      chk("rm_en0", mem_en, 1);
      next_cycle();
      rst = 1'b1;
      settle();
      chk("rm_en1", mem_en, 0);
      chk("rm_stall1", stall_if, 0);
      chk("rm_ack1", if_ack, 0);
      next_cycle();
      rst       = 1'b0;
      mem_rdata = 32'hDEADBEEF;
      settle();
      chk("rm_ack2", if_ack, 0);
      chk("rm_rdata2", if_rdata, 0);
      chk("rm_en2", mem_en, 1);
      chk("rm_addr2", mem_addr, 32'h100);
      next_cycle();
      mem_rdata = 32'hBAD0BAD0;
      settle();
      chk("rm_ack3", if_ack, 0);
      next_cycle();
      mem_rdata = 32'h55AA55AA;
      settle();
      chk("rm_ack4", if_ack, 1);
      chk("rm_rdata4", if_rdata, 32'h55AA55AA);
      next_cycle();
      if_req = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
